// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - shared FSM encodings and default qualification length
package switch_debounce_pkg;

  // 10 ms at 50 MHz
  localparam int DB_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch: 2-flop synchronizer, 4-state qualifier, edge pulses
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic            s1, s2;
  db_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept;
  logic            db_n, rise_n, fall_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      db    <= db_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // The counter stops one short of DB_CYCLES: the edge that would reach it
  // is the acceptance edge, so cnt never holds more than DB_CYCLES-1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s2) begin
          if (DB_CYCLES == 1) begin
            accept  = 1'b1;
            state_n = STABLE_HI;
          end else begin
            state_n = WAIT_HI;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt >= CNT_LAST) begin
          accept  = 1'b1;
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          if (DB_CYCLES == 1) begin
            accept  = 1'b1;
            state_n = STABLE_LO;
          end else begin
            state_n = WAIT_LO;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt >= CNT_LAST) begin
          accept  = 1'b1;
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    db_n   = accept ? ~db : db;
    rise_n = accept & ~db;
    fall_n = accept & db;
  end

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - N_CH independent slide-switch debouncers with edge pulses
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [N_CH-1:0] SW_IN,
  output logic [N_CH-1:0] SW_DB,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .DB_CYCLES(DB_CYCLES)
      ) u_ch (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .sw   (SW_IN[i]),
        .db   (SW_DB[i]),
        .rise (RISE[i]),
        .fall (FALL[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - vector table, reset corner case and randomized window-model check
module tb_switch_debounce;

  localparam int N_CH = 2;
  localparam int DB   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] sw_in = '0;
  logic [N_CH-1:0] sw_db, rise, fall;

  int n_tests = 0;
  int n_fail  = 0;

  switch_debounce #(.N_CH(N_CH), .DB_CYCLES(DB)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW_IN    (sw_in),
    .SW_DB    (sw_db),
    .RISE     (rise),
    .FALL     (fall)
  );

  always #5 clk = ~clk;

  // Reference: the FSM sees SW_IN from two edges earlier; a level flips when
  // the last DB observations all disagree with it.
  logic [DB+1:0][N_CH-1:0] hist;
  logic [DB+1:0][N_CH-1:0] hist_next;
  logic [N_CH-1:0]         m_db, m_rise, m_fall, m_flip;

  function automatic logic [N_CH-1:0] accept_mask(input logic [DB+1:0][N_CH-1:0] h,
                                                  input logic [N_CH-1:0] lvl);
    logic [N_CH-1:0] m;
    m = '1;
    for (int k = 0; k < DB; k++) m = m & (h[2+k] ^ lvl);
    return m;
  endfunction

  always_comb begin
    hist_next = {hist[DB:0], sw_in};
    m_flip    = accept_mask(hist_next, m_db);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist   <= '0;
      m_db   <= '0;
      m_rise <= '0;
      m_fall <= '0;
    end else begin
      hist   <= hist_next;
      m_db   <= m_db ^ m_flip;
      m_rise <= m_flip & ~m_db;
      m_fall <= m_flip & m_db;
    end
  end

  task automatic chk(input string name, input logic [3*N_CH-1:0] got, input logic [3*N_CH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset(input logic [N_CH-1:0] sw);
    @(negedge clk);
    rst   = 1'b1;
    sw_in = sw;
    #1;
    chk("reset", {sw_db, rise, fall}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic [N_CH-1:0] sw);
    @(negedge clk);
    sw_in = sw;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            rst_first;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] rs;
    logic [N_CH-1:0] fl;
  } vec_t;

  vec_t tbl[$];

  task automatic add_run(input logic r, input logic [N_CH-1:0] sw, input logic [N_CH-1:0] db,
                         input logic [N_CH-1:0] rs, input logic [N_CH-1:0] fl, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r && (i == 0), sw, db, rs, fl});
  endtask

  int              run_left [N_CH];
  logic [N_CH-1:0] cur;
  logic [N_CH-1:0] p_db, p_rise, p_fall;

  initial begin
    // clean rise on ch0: accepted at edge 5
    add_run(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add_run(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add_run(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    // 3-cycle glitch rejected
    add_run(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add_run(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8);
    // bounce 1,0,1,1,0 then hold: single rise 5 edges after final 0->1
    add_run(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add_run(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add_run(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add_run(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add_run(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add_run(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add_run(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    // both channels rise together, then ch1 released alone
    add_run(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add_run(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add_run(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add_run(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 5);
    add_run(1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1);
    add_run(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset('0);
      step(tbl[i].sw);
      chk($sformatf("vec%0d", i), {sw_db, rise, fall}, {tbl[i].db, tbl[i].rs, tbl[i].fl});
    end

    // reset mid-WAIT_HI (cnt=2) with ch1 already high, switches held through release
    do_reset('0);
    for (int e = 0; e < 7; e++) step(2'b10);
    chk("pre_rst", {sw_db, rise, fall}, {2'b10, 2'b00, 2'b00});
    for (int e = 0; e < 4; e++) step(2'b11);
    rst = 1'b1;
    #1;
    chk("rst_async", {sw_db, rise, fall}, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 5)
        chk($sformatf("rst_rel%0d", e), {sw_db, rise, fall}, {2'b11, 2'b11, 2'b00});
      else if (e > 5)
        chk($sformatf("rst_rel%0d", e), {sw_db, rise, fall}, {2'b11, 2'b00, 2'b00});
      else
        chk($sformatf("rst_rel%0d", e), {sw_db, rise, fall}, '0);
    end

    // randomized per-channel runs of 1..7 cycles against the window model
    do_reset('0);
    cur = '0;
    for (int c = 0; c < N_CH; c++) run_left[c] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (run_left[c] == 0) begin
          cur[c]      = 1'($urandom_range(0, 1));
          run_left[c] = $urandom_range(1, 7);
        end
        run_left[c]--;
      end
      p_db   = sw_db;
      p_rise = rise;
      p_fall = fall;
      step(cur);
      chk("model", {sw_db, rise, fall}, {m_db, m_rise, m_fall});
      chk("excl", {4'b0, rise & fall}, '0);
      chk("b2b", {4'b0, (rise & p_rise) | (fall & p_fall)}, '0);
      chk("db_pulse", {4'b0, sw_db ^ p_db}, {4'b0, rise | fall});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
